// File: rtl/multi_digit_bcd_counter.sv
// multi_digit_bcd_counter
//   N-digit decimal up/down counter with per-digit active-low 7-segment outputs.
//   Supports synchronous clear, clamped load, saturation and same-cycle carry/borrow
//   so several counters can be cascaded by wiring carryout/borrowout into the next en.
//   Optional feature macro: HEX_LEADING_ZERO_BLANK_EN
//     defined   -> leading zero digits above the most significant nonzero digit are blanked
//     undefined -> every digit is always displayed
module multi_digit_bcd_counter #(
    parameter int NUM_DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      up,
    input  logic                      sat,
    input  logic                      clear,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   load_val,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic [7*NUM_DIGITS-1:0]   hex_out,
    output logic                      carryout,
    output logic                      borrowout,
    output logic                      at_max,
    output logic                      at_zero
);

    localparam int W = 4 * NUM_DIGITS;

    logic [W-1:0]          r_digits;
    logic [W-1:0]          w_nextDigits;
    logic [W-1:0]          w_loadDigits;
    logic                  w_allNine;
    logic                  w_allZero;
    logic [NUM_DIGITS-1:0] w_blank;
`ifdef HEX_LEADING_ZERO_BLANK_EN
    logic                  w_higherZero;
`endif

    // Ripple one BCD step through all digits: a digit that rolls over passes the step upward.
    function automatic logic [W-1:0] bcdStep(input logic [W-1:0] v, input logic dirUp);
        logic [W-1:0] res;
        logic         ripple;
        res    = v;
        ripple = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (ripple) begin
                if (dirUp) begin
                    if (v[4*i +: 4] >= 4'd9) begin
                        res[4*i +: 4] = 4'd0;
                    end else begin
                        res[4*i +: 4] = v[4*i +: 4] + 4'd1;
                        ripple        = 1'b0;
                    end
                end else begin
                    if (v[4*i +: 4] == 4'd0) begin
                        res[4*i +: 4] = 4'd9;
                    end else begin
                        res[4*i +: 4] = v[4*i +: 4] - 4'd1;
                        ripple        = 1'b0;
                    end
                end
            end
        end
        return res;
    endfunction

    // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 is shown blank.
    function automatic logic [6:0] segDecode(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Detect the all-9s and all-0s boundaries used for wrap, saturation and status flags.
    always_comb begin
        w_allNine = 1'b1;
        w_allZero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digits[4*i +: 4] != 4'd9) w_allNine = 1'b0;
            if (r_digits[4*i +: 4] != 4'd0) w_allZero = 1'b0;
        end
    end

    // Clamp each load nibble to 9 so the registers never hold an illegal BCD code.
    always_comb begin
        w_loadDigits = load_val;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) w_loadDigits[4*i +: 4] = 4'd9;
        end
    end

    // Next count with priority clear > load > en; saturation holds at the boundary.
    always_comb begin
        w_nextDigits = r_digits;
        if (clear) begin
            w_nextDigits = '0;
        end else if (load) begin
            w_nextDigits = w_loadDigits;
        end else if (en) begin
            if (up) begin
                if (!(sat && w_allNine)) w_nextDigits = bcdStep(r_digits, 1'b1);
            end else begin
                if (!(sat && w_allZero)) w_nextDigits = bcdStep(r_digits, 1'b0);
            end
        end
    end

    // Digit registers; reset has top priority.
    always_ff @(posedge clk) begin
        if (reset) r_digits <= '0;
        else       r_digits <= w_nextDigits;
    end

    // Work out which digits are suppressed on the display.
    always_comb begin
        w_blank = '0;
`ifdef HEX_LEADING_ZERO_BLANK_EN
        w_higherZero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (w_higherZero && (r_digits[4*i +: 4] == 4'd0)) w_blank[i] = 1'b1;
            else                                              w_higherZero = 1'b0;
        end
`endif
    end

    // Segment drive per digit, blanked where requested.
    always_comb begin
        hex_out = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hex_out[7*i +: 7] = w_blank[i] ? 7'b1111111 : segDecode(r_digits[4*i +: 4]);
        end
    end

    // Status and cascade flags; wraps are only flagged when the step really happens.
    always_comb begin
        bcd_out   = r_digits;
        at_max    = w_allNine;
        at_zero   = w_allZero;
        carryout  = en &  up & w_allNine & ~sat & ~clear & ~load & ~reset;
        borrowout = en & ~up & w_allZero & ~sat & ~clear & ~load & ~reset;
    end

endmodule

// File: tb/tb_multi_digit_bcd_counter.sv
// tb_multi_digit_bcd_counter
//   Directed bench for the 2-digit configuration with hand-computed expectations.
//   Honours HEX_LEADING_ZERO_BLANK_EN for the display expectations.
module tb_multi_digit_bcd_counter;

    localparam logic [6:0] SEG0  = 7'b1000000;
    localparam logic [6:0] SEG1  = 7'b1111001;
    localparam logic [6:0] SEG7  = 7'b1111000;
    localparam logic [6:0] SEG9  = 7'b0010000;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic        clk;
    logic        reset;
    logic        en;
    logic        up;
    logic        sat;
    logic        clear;
    logic        load;
    logic [7:0]  load_val;
    logic [7:0]  bcd_out;
    logic [13:0] hex_out;
    logic        carryout;
    logic        borrowout;
    logic        at_max;
    logic        at_zero;

    int checks = 0;
    int errors = 0;

    multi_digit_bcd_counter #(.NUM_DIGITS(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .sat      (sat),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .bcd_out  (bcd_out),
        .hex_out  (hex_out),
        .carryout (carryout),
        .borrowout(borrowout),
        .at_max   (at_max),
        .at_zero  (at_zero)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expectation and record the result.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Drive all control inputs, then let combinational outputs settle.
    task automatic applyStimulus(input logic iReset, input logic iEn, input logic iUp, input logic iSat,
                                 input logic iClear, input logic iLoad, input logic [7:0] iVal);
        reset    = iReset;
        en       = iEn;
        up       = iUp;
        sat      = iSat;
        clear    = iClear;
        load     = iLoad;
        load_val = iVal;
        #1;
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyStimulus(1, 0, 1, 0, 0, 0, 8'h00);
        tick();
        applyStimulus(0, 0, 1, 0, 0, 0, 8'h00);
        checkOutput("reset_bcd",    32'(bcd_out),   32'h00);
        checkOutput("reset_hex",    32'(hex_out),   32'({SEG0, SEG0}));
        checkOutput("reset_zero",   32'(at_zero),   32'd1);
        checkOutput("reset_max",    32'(at_max),    32'd0);
        checkOutput("reset_carry",  32'(carryout),  32'd0);
        checkOutput("reset_borrow", 32'(borrowout), 32'd0);

        // Count up 99 times, spot-checking the first digit rollover.
        applyStimulus(0, 1, 1, 0, 0, 0, 8'h00);
        for (int k = 1; k <= 99; k++) begin
            if (k == 99) checkOutput("carry_at_98", 32'(carryout), 32'd0);
            tick();
            if (k == 9)  checkOutput("up_to_09", 32'(bcd_out), 32'h09);
            if (k == 10) begin
                checkOutput("up_to_10",  32'(bcd_out), 32'h10);
                checkOutput("hex_10",    32'(hex_out), 32'({SEG1, SEG0}));
            end
        end
        checkOutput("up_to_99",  32'(bcd_out),  32'h99);
        checkOutput("max_99",    32'(at_max),   32'd1);
        checkOutput("hex_99",    32'(hex_out),  32'({SEG9, SEG9}));
        checkOutput("carry_99",  32'(carryout), 32'd1);
        tick();
        checkOutput("wrap_00",       32'(bcd_out),  32'h00);
        checkOutput("carry_after",   32'(carryout), 32'd0);

        // Decrement from zero wraps with borrow; decrement across a tens boundary.
        applyStimulus(0, 1, 0, 0, 0, 0, 8'h00);
        checkOutput("borrow_00", 32'(borrowout), 32'd1);
        tick();
        checkOutput("down_wrap_99",  32'(bcd_out),   32'h99);
        checkOutput("borrow_after",  32'(borrowout), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 1, 8'h10);
        tick();
        checkOutput("load_10", 32'(bcd_out), 32'h10);
        applyStimulus(0, 1, 0, 0, 0, 0, 8'h00);
        tick();
        checkOutput("down_to_09", 32'(bcd_out), 32'h09);
`ifdef HEX_LEADING_ZERO_BLANK_EN
        checkOutput("hex_09", 32'(hex_out), 32'({BLANK, SEG9}));
`else
        checkOutput("hex_09", 32'(hex_out), 32'({SEG0, SEG9}));
`endif

        // Idle holds.
        applyStimulus(0, 0, 1, 0, 0, 0, 8'h00);
        tick();
        checkOutput("idle_hold", 32'(bcd_out), 32'h09);

        // Saturation at both ends.
        applyStimulus(0, 0, 1, 0, 0, 1, 8'h99);
        tick();
        applyStimulus(0, 1, 1, 1, 0, 0, 8'h00);
        checkOutput("sat_carry", 32'(carryout), 32'd0);
        tick();
        checkOutput("sat_hold_99", 32'(bcd_out), 32'h99);
        applyStimulus(0, 0, 1, 0, 0, 1, 8'h00);
        tick();
        applyStimulus(0, 1, 0, 1, 0, 0, 8'h00);
        checkOutput("sat_borrow", 32'(borrowout), 32'd0);
        tick();
        checkOutput("sat_hold_00", 32'(bcd_out), 32'h00);
        applyStimulus(0, 1, 1, 1, 0, 0, 8'h00);
        tick();
        checkOutput("sat_count_01", 32'(bcd_out), 32'h01);

        // Load beats en and clamps illegal nibbles; clear beats load.
        applyStimulus(0, 1, 1, 0, 0, 1, 8'h4C);
        checkOutput("load_no_carry", 32'(carryout), 32'd0);
        tick();
        checkOutput("load_clamp_49", 32'(bcd_out), 32'h49);
        applyStimulus(0, 1, 1, 0, 1, 1, 8'h55);
        tick();
        checkOutput("clear_beats_load", 32'(bcd_out), 32'h00);

        // Clear or reset at all-9s with en suppresses carry and zeroes the count.
        applyStimulus(0, 0, 1, 0, 0, 1, 8'h99);
        tick();
        applyStimulus(0, 1, 1, 0, 1, 0, 8'h00);
        checkOutput("clear_no_carry", 32'(carryout), 32'd0);
        tick();
        checkOutput("clear_en_00", 32'(bcd_out), 32'h00);
        applyStimulus(0, 0, 1, 0, 0, 1, 8'h99);
        tick();
        applyStimulus(1, 1, 1, 0, 0, 0, 8'h00);
        checkOutput("reset_no_carry", 32'(carryout), 32'd0);
        tick();
        checkOutput("reset_en_00", 32'(bcd_out), 32'h00);

        // Display of leading zeros.
        applyStimulus(0, 0, 1, 0, 0, 1, 8'h07);
        tick();
`ifdef HEX_LEADING_ZERO_BLANK_EN
        checkOutput("hex_07", 32'(hex_out), 32'({BLANK, SEG7}));
`else
        checkOutput("hex_07", 32'(hex_out), 32'({SEG0, SEG7}));
`endif
        applyStimulus(0, 0, 1, 0, 0, 1, 8'h70);
        tick();
        checkOutput("hex_70", 32'(hex_out), 32'({SEG7, SEG0}));
        applyStimulus(0, 0, 1, 0, 0, 1, 8'h00);
        tick();
`ifdef HEX_LEADING_ZERO_BLANK_EN
        checkOutput("hex_00", 32'(hex_out), 32'({BLANK, SEG0}));
`else
        checkOutput("hex_00", 32'(hex_out), 32'({SEG0, SEG0}));
`endif
        checkOutput("zero_flag", 32'(at_zero), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
